// File: rtl/tone_detect.sv
// Rising-edge period meter for a square-wave tone, classifying the period as note C/D/E/F.
// Optional macro TONE_DETECT_CONFIRM_EN: note_id changes only after two matching classifications.
`timescale 1ns/1ps
module tone_detect #(
  parameter int unsigned CLKSPEED  = 100000000,
  parameter int unsigned CNT_W     = 21,
  parameter int unsigned TOL_SHIFT = 6,
  parameter int unsigned TIMEOUT   = 1000000
) (
  input  logic             CLK100MHZ,
  input  logic             rst_n,
  input  logic             tone_in,
  output logic [CNT_W-1:0] period_out,
  output logic             period_strobe,
  output logic [2:0]       note_id,
  output logic             tone_present
);

  localparam int unsigned P_C = CLKSPEED / 262;
  localparam int unsigned P_D = CLKSPEED / 294;
  localparam int unsigned P_E = CLKSPEED / 330;
  localparam int unsigned P_F = CLKSPEED / 349;

  localparam logic [CNT_W-1:0] C_LO = CNT_W'(P_C - (P_C >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] C_HI = CNT_W'(P_C + (P_C >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] D_LO = CNT_W'(P_D - (P_D >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] D_HI = CNT_W'(P_D + (P_D >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] E_LO = CNT_W'(P_E - (P_E >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] E_HI = CNT_W'(P_E + (P_E >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] F_LO = CNT_W'(P_F - (P_F >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] F_HI = CNT_W'(P_F + (P_F >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [0:0] {IDLE = 1'b0, MEASURE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic             rise;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             strobe_q, strobe_d;
  logic [2:0]       note_q, note_d;
  logic             present_q, present_d;
  logic [2:0]       class_s;
`ifdef TONE_DETECT_CONFIRM_EN
  logic [2:0]       prev_class_q, prev_class_d;
`endif

  // Lowest note id wins if windows ever overlap.
  function automatic logic [2:0] classify(input logic [CNT_W-1:0] p);
    if (p >= C_LO && p <= C_HI) begin
      return 3'd1;
    end else if (p >= D_LO && p <= D_HI) begin
      return 3'd2;
    end else if (p >= E_LO && p <= E_HI) begin
      return 3'd3;
    end else if (p >= F_LO && p <= F_HI) begin
      return 3'd4;
    end else begin
      return 3'd0;
    end
  endfunction

  assign rise    = sync2_q & ~prev_q;
  assign class_s = classify(counter_q);

  always_ff @(posedge CLK100MHZ) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      state_q   <= IDLE;
      counter_q <= '0;
      period_q  <= '0;
      strobe_q  <= 1'b0;
      note_q    <= 3'd0;
      present_q <= 1'b0;
`ifdef TONE_DETECT_CONFIRM_EN
      prev_class_q <= 3'd0;
`endif
    end else begin
      sync1_q   <= tone_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      counter_q <= counter_d;
      period_q  <= period_d;
      strobe_q  <= strobe_d;
      note_q    <= note_d;
      present_q <= present_d;
`ifdef TONE_DETECT_CONFIRM_EN
      prev_class_q <= prev_class_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
        end else begin
          state_d = IDLE;
        end
      end
      MEASURE: begin
        if (!rise && counter_q == TIMEOUT_C) begin
          state_d = IDLE;
        end else begin
          state_d = MEASURE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A rising edge always beats the timeout, so a period of exactly TIMEOUT is still reported.
  always_comb begin
    counter_d = counter_q;
    period_d  = period_q;
    strobe_d  = 1'b0;
    note_d    = note_q;
`ifdef TONE_DETECT_CONFIRM_EN
    prev_class_d = prev_class_q;
`endif
    case (state_q)
      IDLE: begin
        if (rise) begin
          counter_d = CNT_W'(1);
        end else begin
          counter_d = '0;
        end
      end
      MEASURE: begin
        if (rise) begin
          counter_d = CNT_W'(1);
          period_d  = counter_q;
          strobe_d  = 1'b1;
`ifdef TONE_DETECT_CONFIRM_EN
          if (class_s == prev_class_q) begin
            note_d = class_s;
          end else begin
            note_d = note_q;
          end
          prev_class_d = class_s;
`else
          note_d = class_s;
`endif
        end else if (counter_q == TIMEOUT_C) begin
          counter_d = '0;
          note_d    = 3'd0;
`ifdef TONE_DETECT_CONFIRM_EN
          prev_class_d = 3'd0;
`endif
        end else begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      default: begin
        counter_d = '0;
      end
    endcase
    present_d = (note_d != 3'd0);
  end

  assign period_out    = period_q;
  assign period_strobe = strobe_q;
  assign note_id       = note_q;
  assign tone_present  = present_q;

endmodule

// File: tb/tb_tone_detect.sv
// Scoreboard bench for tone_detect at a scaled-down clock (CLKSPEED 500 kHz, TIMEOUT 4000).
`timescale 1ns/1ps
module tb_tone_detect;

  localparam int CNT_W   = 21;
  localparam int TIMEOUT = 4000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             tone_in;
  logic [CNT_W-1:0] period_out;
  logic             period_strobe;
  logic [2:0]       note_id;
  logic             tone_present;

  tone_detect #(
    .CLKSPEED (500000),
    .CNT_W    (CNT_W),
    .TOL_SHIFT(6),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .CLK100MHZ    (clk),
    .rst_n        (rst_n),
    .tone_in      (tone_in),
    .period_out   (period_out),
    .period_strobe(period_strobe),
    .note_id      (note_id),
    .tone_present (tone_present)
  );

  always #5 clk = ~clk;

  typedef struct {
    int per;
    int note;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_strobe_cyc = 0;
  bit   strobe_prev = 1'b0;
  bit   armed = 1'b0;
  int   last_p = 0;
  int   exp_note_m = 0;
  int   prev_cls_m = 0;
  int   last_rep_p = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Hand-computed windows for CLKSPEED=500000: C[1879,1937] D[1674,1726] E[1492,1538] F[1410,1454]
  function automatic int cls(input int p);
    if (p >= 1879 && p <= 1937) return 1;
    if (p >= 1674 && p <= 1726) return 2;
    if (p >= 1492 && p <= 1538) return 3;
    if (p >= 1410 && p <= 1454) return 4;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push_period(input int p);
    exp_t e;
    int c;
    c = cls(p);
`ifdef TONE_DETECT_CONFIRM_EN
    if (c == prev_cls_m) exp_note_m = c;
    prev_cls_m = c;
`else
    exp_note_m = c;
`endif
    e.per  = p;
    e.note = exp_note_m;
    q.push_back(e);
  endtask

  // Rising edge, high for h cycles, low for l cycles; a rise closes the previous period.
  task automatic send_hl(input int h, input int l);
    if (armed) push_period(last_p);
    armed   = 1'b1;
    last_p  = h + l;
    tone_in = 1'b1;
    repeat (h) @(negedge clk);
    tone_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic send(input int p);
    send_hl(p / 2, p - p / 2);
  endtask

  task automatic model_reset();
    armed      = 1'b0;
    exp_note_m = 0;
    prev_cls_m = 0;
  endtask

  // Monitor: every strobe pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (period_strobe) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_strobe: period_out=%0d with no expected period", period_out);
        end else begin
          e = q.pop_front();
          chk("period_out", int'(period_out), e.per);
          chk("note_id", int'(note_id), e.note);
          chk("tone_present", int'(tone_present), int'(e.note != 0));
          last_rep_p = e.per;
        end
        if (strobe_prev) begin
          n_vec++;
          n_err++;
          $display("FAIL strobe_width: strobe high %0d consecutive cycles, required 1", 2);
        end
        last_strobe_cyc = cyc;
      end
    end
    strobe_prev = period_strobe;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n   = 1'b0;
    tone_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period", int'(period_out), 0);
    chk("rst_strobe", int'(period_strobe), 0);
    chk("rst_note", int'(note_id), 0);
    chk("rst_present", int'(tone_present), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // C tone, then step to F
    repeat (3) send(1907);
    repeat (3) send(1432);
    // Off-note, C window boundaries, D and E
    send(1000);
    send(1937);
    send(1938);
    send(1879);
    send(1878);
    send(1700);
    send(1515);
    // Glitch inside a C period
    repeat (3) send(1907);
    send_hl(954, 446);
    send_hl(1, 507);
    repeat (3) send(1907);
    // A single bad period between C periods
    send(1000);
    repeat (3) send(1907);
    // Stop input and wait for the silence timeout
    send(1907);
    chk("pre_timeout_note", int'(note_id), exp_note_m);
    t = 0;
    while (note_id != 3'd0 && t < TIMEOUT + 100) begin
      @(negedge clk);
      t++;
    end
    chk("timeout_note", int'(note_id), 0);
    chk("timeout_present", int'(tone_present), 0);
    chk("timeout_latency", cyc - last_strobe_cyc, TIMEOUT);
    chk("timeout_period_held", int'(period_out), 1907);
    model_reset();
    repeat (20) @(negedge clk);

    // Re-arm, then reset in the middle of a measurement
    repeat (3) send(1907);
    tone_in = 1'b1;
    if (armed) push_period(last_p);
    repeat (954) @(negedge clk);
    tone_in = 1'b0;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_period", int'(period_out), 0);
    chk("midrst_strobe", int'(period_strobe), 0);
    chk("midrst_note", int'(note_id), 0);
    chk("midrst_present", int'(tone_present), 0);
    rst_n = 1'b1;
    model_reset();
    repeat (100) @(negedge clk);
    repeat (3) send(1907);
    send(1515);
    send(1432);
    repeat (20) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tone_detect.md
Name: tone_detect

Overview:
- Receive-side counterpart of the PWM/square-wave music-box synth.
- Takes a 1-bit tone input from a Pmod pin or loopback of the speaker square wave, and measures the period between rising edges.
- Classifies the period as one of the four keyboard notes: C 262 Hz, D 294 Hz, E 330 Hz, F 349 Hz.
- Reports the note ID and the raw period, and drives LEDs and a future note-logging path.

Parameters:
- CLKSPEED, 100000000, system clock frequency in Hz.
- CNT_W, 21, width of the period counter and period output.
- TOL_SHIFT, 6, match tolerance = nominal_period >> TOL_SHIFT (about 1.56%).
- TIMEOUT, 1000000, clocks without a rising edge before silence is declared; must be ≤ 2^CNT_W-1.

Ports:
- CLK100MHZ  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- tone_in  input  1  asynchronous tone input, square wave.
- period_out  output  CNT_W  last measured period in clocks.
- period_strobe  output  1  one-cycle pulse when period_out updates.
- note_id  output  3  0 = none, 1 = C, 2 = D, 3 = E, 4 = F; held between updates.
- tone_present  output  1  high when note_id != 0.

Behaviour:
- Reset and clocking:
  - One clock, CLK100MHZ; reset is synchronous and active-low on rst_n.
  - Reset values: period_out = 0, period_strobe = 0, note_id = 0, tone_present = 0, state = IDLE, counter = 0, synchronizer flops = 0.
- Input path:
  - tone_in passes through a 2-flop synchronizer, then a registered previous-value flop.
  - edge = sync & ~prev.
  - A rising edge on tone_in is seen as edge 3 cycles later.
- Nominal periods (localparams): P_C = CLKSPEED/262, P_D = CLKSPEED/294, P_E = CLKSPEED/330, P_F = CLKSPEED/349.
  - At 100 MHz: 381679, 340136, 303030, 286532.
  - Window = [P - (P>>TOL_SHIFT), P + (P>>TOL_SHIFT)], inclusive.
  - All bounds are computed at elaboration; no runtime division.
- FSM state IDLE:
  - counter is held at 0.
  - On edge: counter <= 1, go to MEASURE; no strobe.
- FSM state MEASURE:
  - counter increments by 1 each cycle.
  - On edge: period_out <= counter, period_strobe <= 1 next cycle, counter <= 1, stay in MEASURE.
  - Period = exact clock distance between consecutive edges.
- Timeout:
  - In MEASURE with counter == TIMEOUT and no edge: go to IDLE, note_id <= 0, no strobe; period_out is held.
  - Edge and counter == TIMEOUT in the same cycle: edge wins, period TIMEOUT is reported and classifies as 0.
- Classification:
  - Combinational on counter at the edge; registered into note_id in the same cycle that period_out updates.
  - The windows do not overlap at default parameters; if overlapping, the lowest note_id wins.
  - A period outside all windows gives note_id = 0.
- tone_present is registered and equals (note_id != 0) in the same cycle as note_id.
- The counter never wraps because TIMEOUT bounds it.
- Reset asserted mid-measurement returns everything to reset values on the next clock; the first edge after reset only arms the FSM.

Optional Feature:
- Macro: TONE_DETECT_CONFIRM_EN.
- Defined:
  - Adds a register holding the previous classification.
  - note_id and tone_present change only when two consecutive measured periods classify to the same value; this includes changing to 0.
  - A timeout still clears note_id to 0 immediately, and also clears the previous-classification register.
  - period_out and period_strobe are unaffected.
- Undefined: note_id updates on every measured period.

Test Plan:
- Reset, then drive tone_in as a square wave with half-period 190839 (period 381678) -> after the second rising edge, period_out = 381678, period_strobe is a single pulse, note_id = 1, tone_present = 1; confirm mode requires a third edge.
- Step the input from 262 Hz to 349 Hz (half-period 143266) -> period_out = 286532, note_id = 4 at the first new period; confirm mode updates at the second.
- Apply period 100000 (1 kHz), then period 381679 + 5963 (edge of C window) and 381679 + 5964 -> note_id = 0, 1, 0 respectively; strobe fires each period.
- Stop the input after a valid C tone -> exactly TIMEOUT = 1000000 cycles after the last edge, note_id = 0, tone_present = 0, FSM in IDLE, period_out keeps 381678, no strobe.
- Pull rst_n low for one cycle midway through a measurement -> all outputs 0 next cycle; the first subsequent edge produces no strobe and the second edge reports the correct period.
- Glitch: a single 1-cycle high pulse inserted mid-period -> two short periods are reported with note_id = 0; confirm mode keeps note_id = 1 if only one bad period occurs.
